// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake, holds the
// instruction for the decoder and selects the next PC on commit.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o,
    input  logic        commit_i,
    input  logic [1:0]  pc_src_i,
    input  logic [15:0] br_imm_i,
    input  logic [25:0] j_imm_i,
    input  logic [31:0] jr_target_i,
    output logic        fault_o,
    output logic [31:0] fault_pc_o,
    output logic [31:0] retire_count_o
);

    typedef enum logic [1:0] {
        S_RESET,
        S_FETCH,
        S_HOLD,
        S_FAULT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [31:0] retire_q, retire_d;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        next_pc = pc_plus4;
        case (pc_src_i)
            2'b00:   next_pc = pc_plus4;
            2'b01:   next_pc = pc_plus4 + {{14{br_imm_i[15]}}, br_imm_i, 2'b00};
            2'b10:   next_pc = {pc_plus4[31:28], j_imm_i, 2'b00};
            default: next_pc = jr_target_i;
        endcase
    end

    // Only the HOLD state reacts to commit and only FETCH reacts to ack, so stray
    // handshakes in other states fall through to the hold-everything defaults.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        retire_d   = retire_q;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack_i) begin
                    instr_d = imem_rdata_i;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (commit_i) begin
                    retire_d = retire_q + 32'd1;
                    if (next_pc[1:0] == 2'b00) begin
                        pc_d    = next_pc;
                        state_d = S_FETCH;
                    end else begin
                        fault_d    = 1'b1;
                        fault_pc_d = next_pc;
                        state_d    = S_FAULT;
                    end
                end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_RESET;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'd0;
            retire_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
            retire_q   <= retire_d;
        end
    end

    assign imem_req_o     = (state_q == S_FETCH);
    assign imem_addr_o    = pc_q;
    assign instr_o        = instr_q;
    assign instr_valid_o  = (state_q == S_HOLD);
    assign pc_o           = pc_q;
    assign pc_plus4_o     = pc_plus4;
    assign fault_o        = fault_q;
    assign fault_pc_o     = fault_pc_q;
    assign retire_count_o = retire_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a memory responder pushes the expected held
// instruction into a scoreboard on each transfer, popped when instr_valid appears.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } sbEntry_t;

    logic        clock;
    logic        reset;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemRdata;
    logic [31:0] instr;
    logic        instrValid;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        commit;
    logic [1:0]  pcSrc;
    logic [15:0] brImm;
    logic [25:0] jImm;
    logic [31:0] jrTarget;
    logic        fault;
    logic [31:0] faultPc;
    logic [31:0] retireCount;

    sbEntry_t    sbQueue[$];
    int          checkCount = 0;
    int          passCount  = 0;
    logic [31:0] retireExp  = 32'd0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i          (clock),
        .reset_i        (reset),
        .imem_req_o     (imemReq),
        .imem_addr_o    (imemAddr),
        .imem_ack_i     (imemAck),
        .imem_rdata_i   (imemRdata),
        .instr_o        (instr),
        .instr_valid_o  (instrValid),
        .pc_o           (pc),
        .pc_plus4_o     (pcPlus4),
        .commit_i       (commit),
        .pc_src_i       (pcSrc),
        .br_imm_i       (brImm),
        .j_imm_i        (jImm),
        .jr_target_i    (jrTarget),
        .fault_o        (fault),
        .fault_pc_o     (faultPc),
        .retire_count_o (retireCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return addr ^ 32'hDEAD_BEEF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic c, input logic [1:0] src, input logic [15:0] br,
                                 input logic [25:0] j, input logic [31:0] jr);
        commit   = c;
        pcSrc    = src;
        brImm    = br;
        jImm     = j;
        jrTarget = jr;
    endtask

    // Expects FETCH at expAddr; stalls ack waitCycles, with a stray commit in the first stall.
    task automatic fetchInstr(input int waitCycles, input logic [31:0] expAddr);
        sbEntry_t got;
        for (int i = 0; i < waitCycles; i++) begin
            checkOutput("waitReq", {31'd0, imemReq}, 32'd1);
            checkOutput("waitAddr", imemAddr, expAddr);
            checkOutput("waitValid", {31'd0, instrValid}, 32'd0);
            imemAck = 1'b0;
            applyStimulus(i == 0, 2'b11, 16'd0, 26'd0, 32'h0000_0200);
            stepCycle();
            applyStimulus(1'b0, 2'b00, 16'd0, 26'd0, 32'd0);
        end
        if (waitCycles > 0) checkOutput("waitRetire", retireCount, retireExp);
        checkOutput("reqAddr", imemAddr, expAddr);
        checkOutput("req", {31'd0, imemReq}, 32'd1);
        imemAck   = 1'b1;
        imemRdata = memWord(imemAddr);
        sbQueue.push_back('{pc: expAddr, instr: memWord(expAddr)});
        stepCycle();
        imemAck   = 1'b0;
        imemRdata = 32'hxxxx_xxxx;
        checkOutput("valid", {31'd0, instrValid}, 32'd1);
        checkOutput("holdReq", {31'd0, imemReq}, 32'd0);
        if (sbQueue.size() == 0) begin
            checkOutput("sbUnderflow", 32'd0, 32'd1);
        end else begin
            got = sbQueue.pop_front();
            checkOutput("instr", instr, got.instr);
            checkOutput("pc", pc, got.pc);
            checkOutput("pcPlus4", pcPlus4, got.pc + 32'd4);
        end
    endtask

    task automatic commitTo(input logic [1:0] src, input logic [15:0] br, input logic [25:0] j,
                            input logic [31:0] jr, input logic [31:0] expNext);
        applyStimulus(1'b1, src, br, j, jr);
        stepCycle();
        applyStimulus(1'b0, 2'b00, 16'd0, 26'd0, 32'd0);
        retireExp++;
        checkOutput("nextAddr", imemAddr, expNext);
        checkOutput("nextReq", {31'd0, imemReq}, 32'd1);
        checkOutput("nextValid", {31'd0, instrValid}, 32'd0);
        checkOutput("retire", retireCount, retireExp);
    endtask

    task automatic checkResetState();
        checkOutput("rstReq", {31'd0, imemReq}, 32'd0);
        checkOutput("rstAddr", imemAddr, 32'd0);
        checkOutput("rstPcPlus4", pcPlus4, 32'd4);
        checkOutput("rstInstr", instr, 32'd0);
        checkOutput("rstValid", {31'd0, instrValid}, 32'd0);
        checkOutput("rstFault", {31'd0, fault}, 32'd0);
        checkOutput("rstFaultPc", faultPc, 32'd0);
        checkOutput("rstRetire", retireCount, 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        imemAck   = 1'b0;
        imemRdata = 32'd0;
        applyStimulus(1'b0, 2'b00, 16'd0, 26'd0, 32'd0);
        stepCycle();
        stepCycle();
        checkResetState();

        reset = 1'b0;
        stepCycle();
        fetchInstr(0, 32'h0000_0000);
        commitTo(2'b00, 16'd0, 26'd0, 32'd0, 32'h0000_0004);

        fetchInstr(0, 32'h0000_0004);
        commitTo(2'b11, 16'd0, 26'd0, 32'h0000_0100, 32'h0000_0100);
        fetchInstr(3, 32'h0000_0100);
        commitTo(2'b11, 16'd0, 26'd0, 32'h0000_0010, 32'h0000_0010);

        fetchInstr(0, 32'h0000_0010);
        commitTo(2'b01, 16'hFFFC, 26'd0, 32'd0, 32'h0000_0004);
        fetchInstr(1, 32'h0000_0004);
        commitTo(2'b11, 16'd0, 26'd0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        fetchInstr(0, 32'hFFFF_FFFC);
        commitTo(2'b01, 16'h0000, 26'd0, 32'd0, 32'h0000_0000);

        fetchInstr(0, 32'h0000_0000);
        commitTo(2'b11, 16'd0, 26'd0, 32'h3000_0000, 32'h3000_0000);
        fetchInstr(2, 32'h3000_0000);
        commitTo(2'b10, 16'd0, 26'h0000040, 32'd0, 32'h3000_0100);

        fetchInstr(0, 32'h3000_0100);
        applyStimulus(1'b1, 2'b11, 16'd0, 26'd0, 32'h0000_0102);
        stepCycle();
        retireExp++;
        checkOutput("fault", {31'd0, fault}, 32'd1);
        checkOutput("faultPc", faultPc, 32'h0000_0102);
        checkOutput("faultRetire", retireCount, retireExp);
        checkOutput("faultAddr", imemAddr, 32'h3000_0100);
        for (int i = 0; i < 10; i++) begin
            imemAck = 1'b1;
            applyStimulus(1'b1, 2'(i), 16'd0, 26'd0, 32'h0000_0040);
            checkOutput("faultReq", {31'd0, imemReq}, 32'd0);
            checkOutput("faultValid", {31'd0, instrValid}, 32'd0);
            stepCycle();
        end
        imemAck = 1'b0;
        applyStimulus(1'b0, 2'b00, 16'd0, 26'd0, 32'd0);
        checkOutput("faultHeld", {31'd0, fault}, 32'd1);
        checkOutput("faultRetireHeld", retireCount, retireExp);

        reset = 1'b1;
        stepCycle();
        retireExp = 32'd0;
        checkResetState();
        reset = 1'b0;
        stepCycle();
        checkOutput("restartReq", {31'd0, imemReq}, 32'd1);
        checkOutput("restartAddr", imemAddr, 32'd0);

        fetchInstr(0, 32'h0000_0000);
        commitTo(2'b00, 16'd0, 26'd0, 32'd0, 32'h0000_0004);
        imemAck   = 1'b1;
        imemRdata = memWord(imemAddr);
        reset     = 1'b1;
        stepCycle();
        imemAck   = 1'b0;
        retireExp = 32'd0;
        checkOutput("ackRstValid", {31'd0, instrValid}, 32'd0);
        checkOutput("ackRstRetire", retireCount, 32'd0);
        checkOutput("ackRstReq", {31'd0, imemReq}, 32'd0);
        checkOutput("ackRstAddr", imemAddr, 32'd0);
        reset = 1'b0;
        stepCycle();
        fetchInstr(0, 32'h0000_0000);
        commitTo(2'b00, 16'd0, 26'd0, 32'd0, 32'h0000_0004);

        checkOutput("sbDrained", sbQueue.size(), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the single-cycle MIPS datapath. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. It holds each fetched instruction stable for the instruction decoder and, on the decoder's commit, computes the next PC from one of four sources: PC+4, branch, absolute jump, or jump-register. It replaces the free-running PC register and PC-source mux in the CPU top level, and adds misaligned-target detection and a retired-instruction counter.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  byte address of the request; equals current PC.
- imem_ack  in  1  memory has data; a transfer completes on a cycle with imem_req=1 and imem_ack=1.
- imem_rdata  in  32  instruction word, valid only in the transfer cycle.
- instr  out  32  held instruction for the decoder.
- instr_valid  out  1  instr and pc are meaningful.
- pc  out  32  address of the held instruction.
- pc_plus4  out  32  pc + 4, modulo 2^32.
- commit  in  1  decoder retires the held instruction; sampled only while instr_valid=1.
- pc_src  in  2  next-PC select, sampled with commit: 00 pc+4, 01 branch, 10 absolute jump, 11 jump register.
- br_imm  in  16  branch immediate, in words, signed.
- j_imm  in  26  jump target field.
- jr_target  in  32  register value used for jump register.
- fault  out  1  sticky misaligned-target flag.
- fault_pc  out  32  offending target address.
- retire_count  out  32  number of commits since reset; wraps.

## Operation
- States:
  - RESET: entered while reset=1.
  - FETCH: request outstanding.
  - HOLD: instruction valid, waiting for commit.
  - FAULT: fetch halted.
- RESET → FETCH on the first edge with reset=0.
- FETCH:
  - imem_req=1 and imem_addr=PC, held stable until ack.
  - On a transfer: instr ← imem_rdata, instr_valid ← 1, state → HOLD.
- HOLD:
  - instr, pc and pc_plus4 are held constant; imem_req=0.
  - On commit=1, next PC is computed as follows:
    - 00: pc_plus4.
    - 01: pc_plus4 + {{14{br_imm[15]}}, br_imm, 2'b00}, modulo 2^32.
    - 10: {pc_plus4[31:28], j_imm, 2'b00}.
    - 11: jr_target.
  - In the same commit cycle, retire_count increments (wraps 32'hFFFF_FFFF → 0) and instr_valid ← 0.
  - If next PC[1:0] == 2'b00: PC ← next PC, state → FETCH.
  - Otherwise: PC is unchanged, fault ← 1, fault_pc ← next PC, state → FAULT. Only selector 11 can produce this.
- FAULT:
  - imem_req=0, instr_valid=0; commit and imem_ack are ignored.
  - Only reset exits FAULT.
- commit while instr_valid=0 has no effect: no counter change and no PC change.
- imem_ack while imem_req=0 is ignored.

## Timing
- Reset values:
  - PC=RESET_PC, imem_addr=RESET_PC, pc_plus4=RESET_PC+4.
  - imem_req=0, instr=0, instr_valid=0.
  - fault=0, fault_pc=0, retire_count=0.
- imem_req rises in the first cycle after reset is released.
- Fetch latency: with ack in the same cycle as req, instr_valid=1 on the next cycle. Each additional wait cycle of ack adds one cycle.
- Minimum throughput: one instruction per 2 cycles (FETCH, then HOLD with commit=1). imem_req re-asserts in the cycle after commit.
- All outputs are registered or decode only from state and registered values; there is no combinational path from imem_ack or commit to any output.
- Reset mid-operation: reset=1 wins over every other input on that edge. An imem_ack coincident with reset is discarded. Any outstanding request is abandoned, and imem_req=0 from the next cycle.
- fault asserts in the cycle after the offending commit. retire_count includes the faulting instruction.

## Test plan
- Reset release, RESET_PC=0, ack tied high → imem_req=1, imem_addr=0 in cycle 1; instr_valid=1 in cycle 2 with instr=imem_rdata; committing with pc_src=00 produces the next request at addr 4.
- ack delayed 3 cycles → imem_addr stays 0x100 for all 4 request cycles; instr_valid rises exactly one cycle after ack; a commit pulse during the wait changes nothing.
- Branch at pc=0x0000_0010, br_imm=16'hFFFC, pc_src=01 → next imem_addr=0x0000_0004. Branch at pc=0xFFFF_FFFC, br_imm=0 → address wraps to 0x0000_0000.
- Jump at pc=0x3000_0000, j_imm=26'h0000040, pc_src=10 → next address 0x3000_0100; retire_count increments by 1.
- Jump register with jr_target=0x0000_0102 → fault=1 and fault_pc=0x0000_0102 next cycle; imem_req stays 0 for 10+ cycles; reset then restores RESET_PC and clears fault.
- reset asserted in the same cycle as imem_ack → instr_valid stays 0 and retire_count=0; fetch restarts at RESET_PC.
